// File: rtl/aes128_key_inv_expansion.sv
// Inverse AES-128 key schedule: walks backwards from the round-10 key to the cipher key, one round per request.
// Optional build macro AES128_KEY_INV_FAST_XOR_EN collapses the three word XORs into a single cycle.
module aes128_key_inv_expansion #(
  parameter int EXTERNAL_SBOX = 0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [127:0] key_i,
  input  logic         start_i,
  input  logic         key_req_i,
  output logic [127:0] key_o,
  output logic [127:0] key_big_end_o,
  output logic         valid_o,
  output logic [3:0]   round_o,
  output logic [7:0]   sbox_sub_o,
  input  logic [7:0]   sbox_sub_i
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_XOR,
    ST_ROT,
    ST_SUB,
    ST_RCON,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  state_t            state_q, state_d;
  logic [3:0][31:0]  word_q;
  logic [31:0]       temp_q;
  logic [7:0]        rcon_q;
  logic [3:0]        round_q;
  logic              valid_q;
  logic [1:0]        cnt_q;
  logic              settle_q;
  logic              req_ok;
  logic [7:0]        sub_in;
  logic [7:0]        sub_out;

  assign req_ok = key_req_i && valid_q && (round_q != 4'd0) && !start_i;

  // word_q[0] is the first AES word; each word keeps AES byte order internally.
  assign key_big_end_o = {word_q[0], word_q[1], word_q[2], word_q[3]};
  assign valid_o       = valid_q;
  assign round_o       = round_q;

  for (genvar b = 0; b < 16; b++) begin : g_byte_rev
    assign key_o[8*b +: 8] = key_big_end_o[8*(15-b) +: 8];
  end

  always_comb begin
    sub_in = 8'h00;
    case (cnt_q)
      2'd0:    sub_in = temp_q[31:24];
      2'd1:    sub_in = temp_q[23:16];
      2'd2:    sub_in = temp_q[15:8];
      default: sub_in = temp_q[7:0];
    endcase
  end

  assign sub_out    = (EXTERNAL_SBOX != 0) ? sbox_sub_i : sbox_fwd(sub_in);
  assign sbox_sub_o = ((EXTERNAL_SBOX != 0) && (state_q == ST_SUB)) ? sub_in : 8'h00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:  if (req_ok) state_d = ST_XOR;
`ifdef AES128_KEY_INV_FAST_XOR_EN
      ST_XOR:   state_d = ST_ROT;
`else
      ST_XOR:   if (cnt_q == 2'd2) state_d = ST_ROT;
`endif
      ST_ROT:   state_d = ST_SUB;
      ST_SUB:   if (cnt_q == 2'd3) state_d = ST_RCON;
      ST_RCON:  state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  if (settle_q) state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // DONE lasts two cycles so a new key becomes visible a fixed latency after the request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q   <= '0;
      temp_q   <= '0;
      rcon_q   <= 8'h00;
      round_q  <= 4'd0;
      valid_q  <= 1'b0;
      cnt_q    <= 2'd0;
      settle_q <= 1'b0;
    end else begin
      cnt_q <= ((state_q == ST_XOR) || (state_q == ST_SUB)) ? cnt_q + 2'd1 : 2'd0;
      case (state_q)
        ST_WAIT: begin
          if (start_i) begin
            word_q  <= {key_i[31:0], key_i[63:32], key_i[95:64], key_i[127:96]};
            round_q <= 4'd10;
            rcon_q  <= 8'h36;
            valid_q <= 1'b1;
          end else if (req_ok) begin
            valid_q <= 1'b0;
          end
        end
        ST_XOR: begin
`ifdef AES128_KEY_INV_FAST_XOR_EN
          word_q[3] <= word_q[3] ^ word_q[2];
          word_q[2] <= word_q[2] ^ word_q[1];
          word_q[1] <= word_q[1] ^ word_q[0];
`else
          case (cnt_q)
            2'd0:    word_q[3] <= word_q[3] ^ word_q[2];
            2'd1:    word_q[2] <= word_q[2] ^ word_q[1];
            default: word_q[1] <= word_q[1] ^ word_q[0];
          endcase
`endif
        end
        ST_ROT: begin
          temp_q <= {word_q[3][23:0], word_q[3][31:24]};
        end
        ST_SUB: begin
          case (cnt_q)
            2'd0:    temp_q[31:24] <= sub_out;
            2'd1:    temp_q[23:16] <= sub_out;
            2'd2:    temp_q[15:8]  <= sub_out;
            default: temp_q[7:0]   <= sub_out;
          endcase
        end
        ST_RCON: begin
          temp_q[31:24] <= temp_q[31:24] ^ rcon_q;
          rcon_q        <= rcon_q[0] ? (((rcon_q ^ 8'h1B) >> 1) | 8'h80) : (rcon_q >> 1);
        end
        ST_FINAL: begin
          word_q[0] <= word_q[0] ^ temp_q;
          if (round_q != 4'd0) round_q <= round_q - 4'd1;
        end
        ST_DONE: begin
          if (settle_q) begin
            valid_q  <= 1'b1;
            settle_q <= 1'b0;
          end else begin
            settle_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes128_key_inv_expansion.md
Name: aes128_key_inv_expansion

Overview:
Inverse AES-128 key schedule. It is loaded with the round-10 key and walks the schedule backwards, one round per request, until it reaches round 0 (the cipher key). It feeds the decrypt datapath's AddRoundKey stage. The round-key register is updated in place, so no storage for the full schedule is needed.

Parameters:
EXTERNAL_SBOX, 0, 1 = S-box lookups go through the sbox_sub_o/sbox_sub_i pins; 0 = internal forward S-box, sbox_sub_o driven 0.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous, active-low reset
key_i  in  128  round-10 key, AES byte order (byte 0 in [127:120])
start_i  in  1  load key_i as the current key; round set to 10
key_req_i  in  1  request the previous round key
key_o  out  128  current round key, byte-reversed (byte 0 in [7:0]; word j in [32j+:32])
key_big_end_o  out  128  current round key, AES byte order
valid_o  out  1  key_o and round_o are stable and usable
round_o  out  4  round number of the key currently held
sbox_sub_o  out  8  byte to substitute (external S-box)
sbox_sub_i  in  8  substituted byte, combinational, same cycle

Behaviour:
- Reset: key 0, round_o 0, valid_o 0, rcon 8'h00, state WAIT, sbox_sub_o 0.
- Recurrence, with k0..k3 the current words and p0..p3 the previous-round words:
  - p3 = k3^k2, p2 = k2^k1, p1 = k1^k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {24'b0, rcon}.
  - RotWord, little-endian: destination byte (i-1) mod 4 takes source byte i.
  - rcon is XORed into byte 0 only.
- FSM states: WAIT, XOR, ROT, SUB, RCON, FINAL, DONE.
- WAIT:
  - start_i: load key_i, round_o=10, rcon=8'h36, valid_o=1.
  - key_req_i with valid_o=1 and round_o!=0: valid_o<=0, go to XOR.
  - start_i and key_req_i in the same cycle: start wins; the request is dropped.
  - key_req_i when round_o==0 or valid_o==0: ignored, no state change.
- XOR: 3 cycles. Cycle n (n=0..2) computes word 3-n as word(3-n)^word(2-n), descending. Counter is 2-bit.
- ROT: temp <= RotWord(word3).
- SUB:
  - 4 cycles, one byte per cycle, byte 0 first; temp byte replaced by S-box output.
  - Lookup is always the forward (encrypt) S-box.
  - sbox_sub_o is valid only in SUB; 0 otherwise.
- RCON: temp ^= rcon. Then rcon <= inverse-xtime(rcon):
  - if rcon[0]=1: ((rcon^8'h1B)>>1)|8'h80
  - else: rcon>>1
  - sequence: 36,1B,80,40,20,10,08,04,02,01.
- FINAL: word0 <= word0 ^ temp; round_o decrements.
- DONE: valid_o<=1, return to WAIT.
- Latency: request sampled at edge T; valid_o high after edge T+12. The next request is accepted from that cycle.
- Busy behaviour: start_i and key_req_i are ignored outside WAIT. key_o is undefined while valid_o=0.
- Reset asserted mid-operation: all state clears immediately; the in-flight key is lost.
- round_o never underflows; the chain stops at 0.

Optional Feature:
AES128_KEY_INV_FAST_XOR_EN
- Defined: the XOR state computes p3, p2 and p1 in a single cycle using the old word values. Latency becomes 10 cycles (valid after edge T+10).
- Undefined: 3-cycle serial XOR as above; latency 12.
- Key results are identical in both builds.

Test Plan:
- Reset mid-SUB (rst_n_i low for 1 cycle) -> all outputs 0 immediately; a fresh start_i then works normally.
- start_i, key_i=d014f9a8c9ee2589e13f0cc8b6630ca6 -> valid_o=1 next cycle, round_o=10, key_big_end_o equals key_i.
- One key_req_i -> valid_o low for 12 cycles (10 with FAST_XOR), then key_big_end_o=ac7766f319fadc2128d12941575c006e, round_o=9.
- Request 10 times, back-to-back as soon as valid_o=1 -> round 1 key a0fafe1788542cb123a339392a6c7605; round 0 key 2b7e151628aed2a6abf7158809cf4f3c.
- At round_o=0, pulse key_req_i -> valid_o stays 1, key unchanged. Pulse key_req_i mid-operation -> ignored.
- Same-cycle start_i and key_req_i in WAIT -> key reloaded, round_o=10, no expansion starts. Repeat the sequence with EXTERNAL_SBOX=1 and an S-box model on the pins -> same keys.
